// File: rtl/piso_shift_tx_pkg.sv
// Shared definitions for the parallel-in/serial-out transmitter.
//   piso_state_e : frame sequencer states (IDLE, SETUP, HOLD, LATCH)
//   piso_frame_bits() : number of serial bits per frame, data plus optional parity
package piso_shift_tx_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,   // waiting for a word, din_ready high
      ST_SETUP = 2'd1,   // sdata valid, sclk low; next tick raises sclk
      ST_HOLD  = 2'd2,   // sclk high; next tick lowers it and advances
      ST_LATCH = 2'd3    // slatch high for one tick period
   } piso_state_e;

   // Bits on the wire for one frame.
   function automatic int piso_frame_bits(input int width, input bit parity_en);
      return parity_en ? width + 1 : width;
   endfunction

endpackage

// File: rtl/piso_shift_tx.sv
// Purpose   : serialise one parallel word onto sdata/sclk for a 74164/74595-style
//             receiver chain, then pulse slatch to transfer it to the outputs.
// Latency   : 2*N+1 tick periods from accept to done (N = WIDTH, or WIDTH+1 with parity).
// Backpres. : din_ready is high only in IDLE; din/din_valid are ignored mid-frame.
//
// Ports
//   clk_i        system clock, all state changes on its rising edge
//   rst_n_i      synchronous active-low reset
//   tick_i       bit-rate enable, one step of the frame sequencer per clk it is high
//   din_i        parallel word, captured on din_valid_i && din_ready_o
//   din_valid_i  din_i is presented
//   din_ready_o  high only while idle
//   sdata_o      serial data to receiver SER pin, only changes while sclk_o is low
//   sclk_o       shift clock, receiver samples sdata_o on its rise
//   slatch_o     storage-register latch strobe, high for one tick period
//   busy_o       frame in progress (accept edge through LATCH exit)
//   done_o       one-clk pulse when the frame completes
//
// Build option: define PISO_PARITY_EN to append one even-parity bit (^din of the
// accepted word) after the data bits; slatch then follows the parity bit.
module piso_shift_tx
   import piso_shift_tx_pkg::*;
#(
   parameter int WIDTH     = 8,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic             clk_i,
   input  logic             rst_n_i,
   input  logic             tick_i,
   input  logic [WIDTH-1:0] din_i,
   input  logic             din_valid_i,
   output logic             din_ready_o,
   output logic             sdata_o,
   output logic             sclk_o,
   output logic             slatch_o,
   output logic             busy_o,
   output logic             done_o
);

`ifdef PISO_PARITY_EN
   localparam bit PARITY_EN = 1'b1;
`else
   localparam bit PARITY_EN = 1'b0;
`endif

   localparam int NB = piso_frame_bits(WIDTH, PARITY_EN);
   localparam int CW = $clog2(WIDTH + 2);
   localparam logic [CW-1:0] LAST_BIT = CW'(NB - 1);

   piso_state_e      state_q;
   logic [NB-1:0]    shreg_q;
   logic [CW-1:0]    cnt_q;
   logic             sdata_q;
   logic             sclk_q;
   logic             slatch_q;
   logic             busy_q;
   logic             done_q;

   logic [WIDTH-1:0] din_ord;
   logic [NB-1:0]    frame_d;
   logic             accept;

   // Reorder the word so the first bit on the wire always sits at the top of the
   // shift register; the shifter then only ever moves left.
   for (genvar i = 0; i < WIDTH; i++) begin : g_ord
      assign din_ord[i] = MSB_FIRST ? din_i[i] : din_i[WIDTH-1-i];
   end

`ifdef PISO_PARITY_EN
   // Parity is taken from the word as accepted, so it rides out last.
   assign frame_d = {din_ord, ^din_i};
`else
   assign frame_d = din_ord;
`endif

   assign din_ready_o = (state_q == ST_IDLE);
   assign accept      = din_valid_i && din_ready_o;

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         state_q  <= ST_IDLE;
         shreg_q  <= '0;
         cnt_q    <= '0;
         sdata_q  <= 1'b0;
         sclk_q   <= 1'b0;
         slatch_q <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               // A tick coincident with the accept edge is deliberately not acted
               // on, which guarantees a full tick of setup before the first rise.
               if (accept) begin
                  shreg_q <= frame_d;
                  cnt_q   <= '0;
                  sdata_q <= frame_d[NB-1];
                  busy_q  <= 1'b1;
                  state_q <= ST_SETUP;
               end
            end
            ST_SETUP: begin
               if (tick_i) begin
                  sclk_q  <= 1'b1;
                  state_q <= ST_HOLD;
               end
            end
            ST_HOLD: begin
               if (tick_i) begin
                  sclk_q <= 1'b0;
                  if (cnt_q == LAST_BIT) begin
                     slatch_q <= 1'b1;
                     sdata_q  <= 1'b0;
                     state_q  <= ST_LATCH;
                  end else begin
                     // sdata moves on the same edge sclk falls, never while it is high.
                     shreg_q <= shreg_q << 1;
                     sdata_q <= shreg_q[NB-2];
                     cnt_q   <= cnt_q + CW'(1);
                     state_q <= ST_SETUP;
                  end
               end
            end
            ST_LATCH: begin
               if (tick_i) begin
                  slatch_q <= 1'b0;
                  busy_q   <= 1'b0;
                  done_q   <= 1'b1;
                  state_q  <= ST_IDLE;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign sdata_o  = sdata_q;
   assign sclk_o   = sclk_q;
   assign slatch_o = slatch_q;
   assign busy_o   = busy_q;
   assign done_o   = done_q;

endmodule

// File: tb/tb_piso_shift_tx.sv
// Bench for piso_shift_tx: an MSB-first and an LSB-first instance share all inputs.
// Stimulus pushes expected frames/bits into per-instance queues; a monitor per
// instance follows each frame by counting ticks and compares every output.
module tb_piso_shift_tx;

   localparam int W = 8;
`ifdef PISO_PARITY_EN
   localparam int N = W + 1;
`else
   localparam int N = W;
`endif

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         tick = 1'b0;
   logic [W-1:0] din = '0;
   logic         din_valid = 1'b0;

   logic rdy [2];
   logic sd  [2];
   logic sc  [2];
   logic sl  [2];
   logic bz  [2];
   logic dn  [2];

   int n_chk  = 0;
   int n_pass = 0;
   int tick_mode = 0;

   logic [W-1:0] frame_q [2][$];
   bit           exp_q   [2][$];

   always #5 clk = ~clk;

   function automatic void check(input string name, input logic [63:0] act,
                                 input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s @%0t: got %0h want %0h", name, $time, act, exp);
   endfunction

   // Reference: order of bits on the wire for a word.
   function automatic logic [N-1:0] wire_bits(input logic [W-1:0] w, input bit msb);
      logic [N-1:0] b;
      b = '0;
      for (int i = 0; i < W; i++) b[i] = msb ? w[W-1-i] : w[i];
`ifdef PISO_PARITY_EN
      b[W] = ^w;
`endif
      return b;
   endfunction

   for (genvar g = 0; g < 2; g++) begin : g_chk
      localparam bit MF = (g == 0);

      piso_shift_tx #(.WIDTH(W), .MSB_FIRST(MF)) u_dut (
         .clk_i      (clk),
         .rst_n_i    (rst_n),
         .tick_i     (tick),
         .din_i      (din),
         .din_valid_i(din_valid),
         .din_ready_o(rdy[g]),
         .sdata_o    (sd[g]),
         .sclk_o     (sc[g]),
         .slatch_o   (sl[g]),
         .busy_o     (bz[g]),
         .done_o     (dn[g])
      );

      bit           in_frame = 1'b0;
      bit           p_acc = 1'b0;
      bit           p_tick = 1'b0;
      bit           p_rst = 1'b0;
      bit           prev_sclk = 1'b0;
      int           t = 0;
      logic [N-1:0] fbits = '0;

      // Negedge: first account for what the previous rising edge did, then
      // compare outputs, then latch the inputs the next rising edge will see.
      always @(negedge clk) begin
         logic [5:0]   e;
         logic [5:0]   a;
         logic [W-1:0] w;
         bit           eb;
         if (!p_rst) begin
            in_frame = 1'b0;
            t = 0;
            exp_q[g].delete();
         end else if (in_frame) begin
            if (p_tick) t++;
         end else if (p_acc) begin
            if (frame_q[g].size() == 0) begin
               n_chk++;
               $display("FAIL accept[%0d] @%0t: got accept want no frame issued", g, $time);
            end else begin
               w = frame_q[g].pop_front();
               fbits = wire_bits(w, MF);
               in_frame = 1'b1;
               t = 0;
            end
         end

         // {ready, busy, sdata, sclk, slatch, done}
         if (in_frame) begin
            e[5] = !(t <= 2 * N);
            e[4] = (t <= 2 * N);
            e[3] = (t < 2 * N) ? fbits[t / 2] : 1'b0;
            e[2] = (t % 2 == 1) && (t < 2 * N);
            e[1] = (t == 2 * N);
            e[0] = (t == 2 * N + 1);
         end else begin
            e = 6'b100000;
         end
         a = {rdy[g], bz[g], sd[g], sc[g], sl[g], dn[g]};
         check($sformatf("outs[%0d] t=%0d rdy,busy,sdata,sclk,slatch,done", g, t),
               64'(a), 64'(e));

         if (sc[g] && !prev_sclk) begin
            if (exp_q[g].size() == 0) begin
               n_chk++;
               $display("FAIL bit[%0d] @%0t: got sclk rise want none queued", g, $time);
            end else begin
               eb = exp_q[g].pop_front();
               check($sformatf("bit[%0d]", g), 64'(sd[g]), 64'(eb));
            end
         end
         if (dn[g]) check($sformatf("bits_left[%0d]", g), 64'(exp_q[g].size()), 64'd0);

         if (in_frame && t == 2 * N + 1) in_frame = 1'b0;

         p_rst     = rst_n;
         p_tick    = tick;
         p_acc     = din_valid && !in_frame;
         prev_sclk = sc[g];
      end
   end

   // Tick generator, changes just after each rising edge.
   initial begin
      int tdiv;
      tdiv = 0;
      forever begin
         @(posedge clk);
         #1;
         tdiv = (tdiv + 1) % 4;
         case (tick_mode)
            0:       tick = 1'b1;
            1:       tick = (tdiv == 0);
            default: tick = ($urandom_range(0, 2) == 0);
         endcase
      end
   end

   task automatic send(input logic [W-1:0] w);
      int           guard;
      logic [N-1:0] b;
      guard = 0;
      @(posedge clk);
      #1;
      din = w;
      din_valid = 1'b1;
      @(negedge clk);
      while (!rdy[0] && guard < 1000) begin
         @(negedge clk);
         guard++;
      end
      if (guard >= 1000) begin
         n_chk++;
         $display("FAIL send_timeout @%0t: got ready=0 want ready within 1000 clks", $time);
         din_valid = 1'b0;
         return;
      end
      for (int g = 0; g < 2; g++) begin
         frame_q[g].push_back(w);
         b = wire_bits(w, g == 0);
         for (int i = 0; i < N; i++) exp_q[g].push_back(b[i]);
      end
      @(posedge clk);
      #1;
      din_valid = 1'b0;
      din = W'($urandom);
   endtask

   task automatic wait_done();
      int guard;
      guard = 0;
      @(negedge clk);
      while (!dn[0] && guard < 2000) begin
         @(negedge clk);
         guard++;
      end
      if (guard >= 2000) begin
         n_chk++;
         $display("FAIL done_timeout @%0t: got no done want done within 2000 clks", $time);
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog @%0t: got no finish want finish", $time);
      $fatal(1, "watchdog expired");
   end

   initial begin
      int rises;
      bit prev;

      // Reset held for two edges; the monitor checks reset values on each.
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;

      // Tick held high: one step per clk.
      tick_mode = 0;
      send(8'hA5);
      wait_done();

      // Tick every 4th clk.
      tick_mode = 1;
      send(8'h01);
      wait_done();

      // Stray word presented mid-frame must be ignored.
      send(8'h3C);
      repeat (5) @(posedge clk);
      #1;
      din = 8'hFF;
      din_valid = 1'b1;
      repeat (6) @(posedge clk);
      #1;
      din_valid = 1'b0;
      wait_done();

      // Reset after the third sclk rise drops the frame.
      send(8'h5A);
      rises = 0;
      prev = 1'b0;
      for (int k = 0; k < 1000 && rises < 3; k++) begin
         @(negedge clk);
         if (sc[0] && !prev) rises++;
         prev = sc[0];
      end
      check("reset_setup_rises", 64'(rises), 64'd3);
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (3) @(posedge clk);
      send(8'h96);
      wait_done();

      // Words with odd and even parity.
      tick_mode = 0;
      send(8'h07);
      wait_done();
      send(8'h03);
      wait_done();

      // Random words and tick patterns.
      for (int k = 0; k < 24; k++) begin
         tick_mode = $urandom_range(0, 2);
         send(W'($urandom));
         wait_done();
      end

      repeat (10) @(negedge clk);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
